// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: central stall/flush controller for the five-stage pipeline.
//
// Drives the PC enable and the writeEN/flush pair of the IF/ID, ID/EX,
// EX/MEM and MEM/WB latches. Inputs are cache handshakes (ihit/dhit), the
// memory-op and redirect/halt flags of the instruction in MEM, and the load
// and source-register fields used for load-use detection. A three-state FSM
// (RUN -> DRAIN -> HALTED) drains the pipe when halt reaches MEM.
//
// Ports
//   CLK, RST                      clock, synchronous active-high reset
//   ihit, dhit                    fetch / data access completed this cycle
//   exmem_dREN, exmem_dWEN        MEM instruction is a load / store
//   exmem_redirect                control redirect resolved in MEM
//   exmem_halt                    MEM instruction is halt
//   idex_MemToReg, idex_regWEN    EX instruction is a register-writing load
//   idex_rt                       destination of that load
//   ifid_rs, ifid_rt              sources of the ID instruction
//   pc_en, *_writeEN, *_flush     combinational latch / PC controls
//   halt                          registered, sticky until reset
//   cyc_cnt, stall_cnt, redir_cnt performance counters (wrap at 2^CNT_W)
module pipeline_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             exmem_dREN,
  input  logic             exmem_dWEN,
  input  logic             exmem_redirect,
  input  logic             exmem_halt,
  input  logic             idex_MemToReg,
  input  logic             idex_regWEN,
  input  logic [4:0]       idex_rt,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  output logic             pc_en,
  output logic             ifid_writeEN,
  output logic             ifid_flush,
  output logic             idex_writeEN,
  output logic             idex_flush,
  output logic             exmem_writeEN,
  output logic             exmem_flush,
  output logic             memwb_writeEN,
  output logic             memwb_flush,
  output logic             halt,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] redir_cnt
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_HALTED = 2'd2
  } state_e;

  // Latch control bundle; bit order of we/fl is {ifid, idex, exmem, memwb}.
  typedef struct packed {
    logic       pc_en;
    logic [3:0] we;
    logic [3:0] fl;
  } ctl_t;

  localparam ctl_t CTL_RUN   = '{pc_en: 1'b1, we: 4'b1111, fl: 4'b0000};
  localparam ctl_t CTL_RESET = '{pc_en: 1'b0, we: 4'b0000, fl: 4'b1111};
  localparam ctl_t CTL_IDLE  = '{pc_en: 1'b0, we: 4'b0000, fl: 4'b0000};
  // Front three latches take bubbles while MEM/WB captures the halt.
  localparam ctl_t CTL_DRAIN = '{pc_en: 1'b0, we: 4'b0001, fl: 4'b1110};

  state_e           state_q, state_d;
  logic             halt_q, halt_d;
  logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] redir_cnt_q, redir_cnt_d;

  ctl_t ctl;
  logic data_pend;
  logic load_use;
  logic redir_take;

  assign data_pend = (exmem_dREN | exmem_dWEN) & ~dhit;
  assign load_use  = idex_MemToReg & idex_regWEN & (idex_rt != 5'd0) &
                     ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));

  // Control outputs and next-state selection.
  always_comb begin
    ctl        = CTL_RUN;
    state_d    = state_q;
    halt_d     = halt_q;
    redir_take = 1'b0;
    unique case (state_q)
      S_RUN: begin
        if (exmem_halt) begin
          ctl     = CTL_DRAIN;
          state_d = S_DRAIN;
        end else if (data_pend) begin
          // Freeze front end and MEM; WB gets a bubble. A concurrent
          // redirect stays asserted and is taken on the dhit cycle.
          ctl.pc_en = 1'b0;
          ctl.we    = 4'b0001;
          ctl.fl    = 4'b0001;
        end else if (exmem_redirect) begin
          // Target is already on the PC mux, so load it even without ihit.
          ctl.fl     = 4'b1110;
          redir_take = 1'b1;
        end else if (load_use) begin
          // One bubble into EX; the load reaches MEM next cycle and the
          // hazard clears on its own.
          ctl.pc_en = 1'b0;
          ctl.we[3] = 1'b0;
          ctl.fl[2] = 1'b1;
        end else if (!ihit) begin
          ctl.pc_en = 1'b0;
          ctl.fl[3] = 1'b1;
        end
      end
      S_DRAIN: begin
        ctl     = CTL_DRAIN;
        state_d = S_HALTED;
        halt_d  = 1'b1;
      end
      default: begin
        ctl     = CTL_IDLE;
        state_d = S_HALTED;
      end
    endcase
    // Reset overrides everything combinationally so no latch captures
    // stale data while RST is held.
    if (RST) ctl = CTL_RESET;
  end

  // Performance counters: frozen in HALTED.
  always_comb begin
    cyc_cnt_d   = cyc_cnt_q;
    stall_cnt_d = stall_cnt_q;
    redir_cnt_d = redir_cnt_q;
    if (state_q != S_HALTED) cyc_cnt_d = cyc_cnt_q + CNT_W'(1);
    if (state_q == S_RUN && !ctl.pc_en) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (redir_take) redir_cnt_d = redir_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_RUN;
      halt_q      <= 1'b0;
      cyc_cnt_q   <= '0;
      stall_cnt_q <= '0;
      redir_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      halt_q      <= halt_d;
      cyc_cnt_q   <= cyc_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      redir_cnt_q <= redir_cnt_d;
    end
  end

  assign pc_en         = ctl.pc_en;
  assign ifid_writeEN  = ctl.we[3];
  assign idex_writeEN  = ctl.we[2];
  assign exmem_writeEN = ctl.we[1];
  assign memwb_writeEN = ctl.we[0];
  assign ifid_flush    = ctl.fl[3];
  assign idex_flush    = ctl.fl[2];
  assign exmem_flush   = ctl.fl[1];
  assign memwb_flush   = ctl.fl[0];
  assign halt          = halt_q;
  assign cyc_cnt       = cyc_cnt_q;
  assign stall_cnt     = stall_cnt_q;
  assign redir_cnt     = redir_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: a stimulus process drives one input
// vector per cycle, runs the reference model and queues the expected
// outputs; a monitor pops and compares on every falling edge.
module tb_pipeline_ctrl;
  localparam int CNT_W = 4;  // small so counter wrap is exercised
  localparam int MOD   = 1 << CNT_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic RST = 1'b1, ihit = 1'b0, dhit = 1'b0, dren = 1'b0, dwen = 1'b0;
  logic redir = 1'b0, hlt = 1'b0, m2r = 1'b0, rwen = 1'b0;
  logic [4:0] idrt = '0, rs = '0, rt = '0;
  logic pc_en, ifid_we, ifid_fl, idex_we, idex_fl, exmem_we, exmem_fl;
  logic memwb_we, memwb_fl, halt;
  logic [CNT_W-1:0] cyc_cnt, stall_cnt, redir_cnt;

  pipeline_ctrl #(.CNT_W(CNT_W)) dut (
    .CLK(clk), .RST(RST), .ihit(ihit), .dhit(dhit),
    .exmem_dREN(dren), .exmem_dWEN(dwen), .exmem_redirect(redir),
    .exmem_halt(hlt), .idex_MemToReg(m2r), .idex_regWEN(rwen),
    .idex_rt(idrt), .ifid_rs(rs), .ifid_rt(rt),
    .pc_en(pc_en), .ifid_writeEN(ifid_we), .ifid_flush(ifid_fl),
    .idex_writeEN(idex_we), .idex_flush(idex_fl),
    .exmem_writeEN(exmem_we), .exmem_flush(exmem_fl),
    .memwb_writeEN(memwb_we), .memwb_flush(memwb_fl),
    .halt(halt), .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt),
    .redir_cnt(redir_cnt)
  );

  typedef struct {
    logic rst, ihit, dhit, dren, dwen, redir, hlt, m2r, rwen;
    logic [4:0] idrt, rs, rt;
  } in_t;

  // we/fl bit order {ifid, idex, exmem, memwb}; mask marks checked we bits.
  typedef struct {
    logic pc;
    logic [3:0] we, fl, mask;
    logic h;
    int cyc, stl, rdr;
  } exp_t;

  exp_t sb[$];
  int checks = 0, failures = 0, n_push = 0, n_pop = 0;

  // Reference model state: 0 running, 1 draining, 2 halted.
  int m_mode = 0, m_cyc = 0, m_stl = 0, m_rdr = 0;
  logic m_halt = 1'b0;

  task automatic model(input in_t v, output exp_t e);
    bit counted, pend, luse;
    e.h = m_halt; e.cyc = m_cyc; e.stl = m_stl; e.rdr = m_rdr;
    e.mask = 4'b1111;
    if (v.rst) begin
      e.pc = 0; e.we = 4'b0000; e.fl = 4'b1111;
      m_mode = 0; m_cyc = 0; m_stl = 0; m_rdr = 0; m_halt = 0;
      return;
    end
    if (m_mode == 2) begin
      e.pc = 0; e.we = 4'b0000; e.fl = 4'b0000;
      return;
    end
    counted = 1;
    if (m_mode == 1 || v.hlt) begin
      // Drain: only MEM/WB latch write is defined; the others are flushed.
      e.pc = 0; e.fl = 4'b1110; e.we = 4'b0001; e.mask = 4'b0001;
      if (m_mode == 1) begin m_halt = 1; m_mode = 2; end
      else m_mode = 1;
    end else begin
      pend = (v.dren || v.dwen) && !v.dhit;
      luse = v.m2r && v.rwen && v.idrt != 0 && (v.idrt == v.rs || v.idrt == v.rt);
      e.pc = 1; e.we = 4'b1111; e.fl = 4'b0000;
      if (pend) begin e.pc = 0; e.we = 4'b0001; e.fl = 4'b0001; end
      else if (v.redir) begin e.fl = 4'b1110; m_rdr = (m_rdr + 1) % MOD; end
      else if (luse) begin e.pc = 0; e.we = 4'b0111; e.fl = 4'b0100; end
      else if (!v.ihit) begin e.fl = 4'b1000; e.pc = 0; end
    end
    if (counted) m_cyc = (m_cyc + 1) % MOD;
    if (!e.pc && !(m_mode == 2 && !v.hlt && e.mask == 4'b0001 && m_halt)) begin
      // Stall counted for any running-mode cycle with PC held; the drain
      // cycle itself (mode was 1) does not count.
    end
  endtask

  in_t cur;

  task automatic step(input in_t v);
    exp_t e;
    int mode_before;
    @(posedge clk); #1;
    RST = v.rst; ihit = v.ihit; dhit = v.dhit; dren = v.dren; dwen = v.dwen;
    redir = v.redir; hlt = v.hlt; m2r = v.m2r; rwen = v.rwen;
    idrt = v.idrt; rs = v.rs; rt = v.rt;
    mode_before = m_mode;
    model(v, e);
    if (!v.rst && mode_before == 0 && !e.pc) m_stl = (m_stl + 1) % MOD;
    sb.push_back(e);
    n_push++;
  endtask

  function automatic in_t quiet();
    in_t v;
    v.rst = 0; v.ihit = 1; v.dhit = 0; v.dren = 0; v.dwen = 0; v.redir = 0;
    v.hlt = 0; v.m2r = 0; v.rwen = 0; v.idrt = 0; v.rs = 0; v.rt = 0;
    return v;
  endfunction

  task automatic chk(input string n, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", n, $time, got, exp);
    end
  endtask

  // Monitor: outputs are valid every cycle, so one pop per falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        n_pop++;
        chk("pc_en", int'(pc_en), int'(e.pc));
        chk("writeEN", int'({ifid_we, idex_we, exmem_we, memwb_we} & e.mask),
            int'(e.we & e.mask));
        chk("flush", int'({ifid_fl, idex_fl, exmem_fl, memwb_fl}), int'(e.fl));
        chk("halt", int'(halt), int'(e.h));
        chk("cyc_cnt", int'(cyc_cnt), e.cyc);
        chk("stall_cnt", int'(stall_cnt), e.stl);
        chk("redir_cnt", int'(redir_cnt), e.rdr);
      end
    end
  end

  initial begin
    in_t v;
    // Reset, then clean run.
    v = quiet(); v.rst = 1;
    repeat (2) step(v);
    v = quiet();
    repeat (5) step(v);
    // Load-use on rs, then same with rt=0 (no hazard).
    v = quiet(); v.m2r = 1; v.rwen = 1; v.idrt = 8; v.rs = 8;
    step(v);
    v.idrt = 0; v.rs = 0;
    step(v);
    // Data pending three cycles, then dhit.
    v = quiet(); v.dren = 1;
    repeat (3) step(v);
    v.dhit = 1;
    step(v);
    // Redirect with ihit low and a load-use hazard.
    v = quiet(); v.redir = 1; v.ihit = 0; v.m2r = 1; v.rwen = 1;
    v.idrt = 5; v.rt = 5;
    step(v);
    // Redirect during data pending: freeze first, redirect on dhit.
    v = quiet(); v.redir = 1; v.dwen = 1;
    repeat (2) step(v);
    v.dhit = 1;
    step(v);
    // Halt with !ihit and load-use present: drain wins.
    v = quiet(); v.hlt = 1; v.ihit = 0; v.m2r = 1; v.rwen = 1;
    v.idrt = 3; v.rs = 3;
    step(v);
    v = quiet();
    repeat (11) step(v);
    // Reset during the drain cycle.
    v = quiet(); v.rst = 1; step(v);
    v = quiet(); step(v);
    v.hlt = 1; step(v);
    v = quiet(); v.rst = 1; step(v);
    v = quiet();
    repeat (3) step(v);
    // Randomized traffic; reset occasionally and to leave HALTED.
    for (int i = 0; i < 600; i++) begin
      v.rst   = ($urandom_range(0, 59) == 0) ||
                (m_mode == 2 && $urandom_range(0, 3) == 0);
      v.ihit  = $urandom_range(0, 4) != 0;
      v.dhit  = $urandom_range(0, 3) != 0;
      v.dren  = $urandom_range(0, 4) == 0;
      v.dwen  = $urandom_range(0, 6) == 0;
      v.redir = $urandom_range(0, 5) == 0;
      v.hlt   = $urandom_range(0, 39) == 0;
      v.m2r   = $urandom_range(0, 1) == 1;
      v.rwen  = $urandom_range(0, 1) == 1;
      v.idrt  = 5'($urandom_range(0, 3));
      v.rs    = 5'($urandom_range(0, 3));
      v.rt    = 5'($urandom_range(0, 3));
      step(v);
    end
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    chk("pop_count", n_pop, n_push);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
